// File: rtl/mem_access_unit_pkg.sv
// Shared constants, encodings and request-legality helper for the memory-stage sequencer.
package mem_access_unit_pkg;

  localparam int DEF_WIDTH   = 32;  // data/address width
  localparam int DEF_TIMEOUT = 8;   // WAIT cycles allowed before a load is aborted

  // Access size as carried on req_size and mem_mode.
  typedef enum logic [1:0] {
    SZ_WORD    = 2'd0,
    SZ_HALF    = 2'd1,
    SZ_BYTE    = 2'd2,
    SZ_ILLEGAL = 2'd3
  } size_e;

  // Sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_WAIT   = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERR    = 3'd5
  } state_e;

  // A request is rejected for an illegal size or an address not aligned to its size.
  function automatic logic req_is_bad(input size_e size, input logic [1:0] addr_lo);
    return (size == SZ_ILLEGAL)
        || ((size == SZ_WORD) && (addr_lo != 2'b00))
        || ((size == SZ_HALF) && addr_lo[0]);
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Pipeline request/response handshake plus data-memory control signals.
// The shared data bus is not carried here: it is a tristate net and stays a
// plain inout port so it resolves at the level where memory and unit meet.
interface mem_access_unit_if #(
  parameter int WIDTH = mem_access_unit_pkg::DEF_WIDTH
) ();

  // Pipeline side
  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [1:0]       req_size;
  logic             req_signed;
  logic [WIDTH-1:0] req_addr;
  logic [WIDTH-1:0] req_wdata;
  logic             resp_valid;
  logic [WIDTH-1:0] resp_data;
  logic             resp_err;

  // Data-memory side
  logic [WIDTH-1:0] mem_add;
  logic             mem_wr;
  logic             mem_rd;
  logic             mem_rd_st;
  logic [1:0]       mem_mode;

  // Environment: issues requests and models the memory.
  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rd_st,
    input  req_ready, resp_valid, resp_data, resp_err, mem_add, mem_wr, mem_rd, mem_mode
  );

  // Sequencer: accepts requests and drives the memory.
  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rd_st,
    output req_ready, resp_valid, resp_data, resp_err, mem_add, mem_wr, mem_rd, mem_mode
  );

endinterface

// File: rtl/mem_access_unit_load_extend.sv
// Combinational size/sign extension of the word returned by a load.
module mem_access_unit_load_extend
  import mem_access_unit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  size_e            size_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] data_o
);

  // Select the low byte/halfword and fill the upper bits with zero or its sign bit.
  always_comb begin
    data_o = raw_i;
    unique case (size_i)
      SZ_BYTE: data_o = {{(WIDTH-8){signed_i & raw_i[7]}}, raw_i[7:0]};
      SZ_HALF: data_o = {{(WIDTH-16){signed_i & raw_i[15]}}, raw_i[15:0]};
      default: data_o = raw_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage sequencer: takes one load/store from EX/MEM, sequences the
// data-memory address/mode/strobes/bus, and returns the (extended) result.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_access_unit_if.slave bus,
  inout  wire [WIDTH-1:0]  mem_data
);

  localparam int               CNT_W     = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

  state_e           state_q, state_d;
  logic             we_q;
  size_e            size_q;
  logic             signed_q;
  logic [WIDTH-1:0] addr_q;
  logic [WIDTH-1:0] wdata_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] resp_data_q, resp_data_d;
  logic [WIDTH-1:0] load_word;
  logic             accept;
  logic             drive_en;

  assign accept = (state_q == ST_IDLE) && bus.req_valid;

  // Hold the accepted request for the whole access; the pipeline may change its inputs meanwhile.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q     <= 1'b0;
      size_q   <= SZ_WORD;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else if (accept) begin
      // NOTE: state is updated with <= so every register samples pre-edge values, independent of block order.
      we_q     <= bus.req_we;
      size_q   <= size_e'(bus.req_size);
      signed_q <= bus.req_signed;
      addr_q   <= bus.req_addr;
      wdata_q  <= bus.req_wdata;
    end
  end

  // FSM state, WAIT timeout counter and response data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      resp_data_q <= resp_data_d;
    end
  end

  mem_access_unit_load_extend #(
    .WIDTH(WIDTH)
  ) u_load_extend (
    .size_i  (size_q),
    .signed_i(signed_q),
    .raw_i   (mem_data),
    .data_o  (load_word)
  );

  // Next-state logic: accept/reject, strobe sequencing, load capture and timeout.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no inferred latch).
    state_d     = state_q;
    cnt_d       = cnt_q;
    resp_data_d = resp_data_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          resp_data_d = '0;
          cnt_d       = '0;
          state_d     = req_is_bad(size_e'(bus.req_size), bus.req_addr[1:0]) ? ST_ERR : ST_SETUP;
        end
      end
      ST_SETUP:  state_d = ST_STROBE;
      ST_STROBE: state_d = we_q ? ST_DONE : ST_WAIT;
      ST_WAIT: begin
        if (bus.mem_rd_st == 1'b1) begin
          resp_data_d = load_word;
          state_d     = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == CNT_LIMIT) begin
            state_d = ST_ERR;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR: begin
        resp_data_d = '0;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from the current state only, so reset drops strobes and bus drive at once.
  always_comb begin
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_err   = 1'b0;
    bus.mem_wr     = 1'b0;
    bus.mem_rd     = 1'b0;
    drive_en       = 1'b0;
    unique case (state_q)
      ST_IDLE:   bus.req_ready = 1'b1;
      ST_SETUP:  drive_en = we_q;
      ST_STROBE: begin
        drive_en   = we_q;
        bus.mem_wr = we_q;
        bus.mem_rd = !we_q;
      end
      ST_WAIT:   ;
      ST_DONE:   bus.resp_valid = 1'b1;
      ST_ERR: begin
        bus.resp_valid = 1'b1;
        bus.resp_err   = 1'b1;
      end
      default:   ;
    endcase
  end

  assign bus.mem_add   = addr_q;
  assign bus.mem_mode  = size_q;
  assign bus.resp_data = resp_data_q;
  assign mem_data      = drive_en ? wdata_q : {WIDTH{1'bz}};

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus random requests
// scored against a transaction-level model of latency, strobes, bus and result.
module tb_mem_access_unit;

  localparam int W  = 32;
  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         mem_drive;
  logic [W-1:0] mem_rdata;
  wire  [W-1:0] mem_data;
  logic         bus_free;

  int errors = 0;
  int checks = 0;

  mem_access_unit_if #(.WIDTH(W)) bus_if ();

  mem_access_unit #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus_if),
    .mem_data(mem_data)
  );

  assign mem_data = mem_drive ? mem_rdata : {W{1'bz}};
  assign bus_free = (mem_data === {W{1'bz}});

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference rules: legality and load extension by plain arithmetic.
  function automatic bit model_bad(input logic [1:0] size, input logic [W-1:0] addr);
    if (size == 2'd3) return 1'b1;
    if (size == 2'd0) return (addr % 4) != 0;
    if (size == 2'd1) return (addr % 2) != 0;
    return 1'b0;
  endfunction

  function automatic logic [W-1:0] model_ext(input logic [1:0] size, input bit sgn, input logic [W-1:0] raw);
    logic [W-1:0] v;
    v = raw;
    if (size == 2'd2) begin
      v = raw % 256;
      if (sgn && v >= 128) v = v - 256;
    end else if (size == 2'd1) begin
      v = raw % 65536;
      if (sgn && v >= 32768) v = v - 65536;
    end
    return v;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"},   bus_if.req_ready,  1);
    check({tag, "_rvalid"},  bus_if.resp_valid, 0);
    check({tag, "_rdata"},   bus_if.resp_data,  0);
    check({tag, "_rerr"},    bus_if.resp_err,   0);
    check({tag, "_add"},     bus_if.mem_add,    0);
    check({tag, "_mode"},    bus_if.mem_mode,   0);
    check({tag, "_wr"},      bus_if.mem_wr,     0);
    check({tag, "_rd"},      bus_if.mem_rd,     0);
    check({tag, "_bus_z"},   bus_free,          1);
  endtask

  // One request from an IDLE negedge to the negedge after its response.
  // w: WAIT cycle (1-based) in which memory answers a load; w > TO means never.
  task automatic run_req(input string tag, input bit we, input logic [1:0] size, input bit sgn,
                         input logic [W-1:0] addr, input logic [W-1:0] wdata,
                         input logic [W-1:0] rdata, input int w);
    bit           bad;
    int           exp_lat, exp_strobe, n, n_resp, n_strobe, n_rd;
    int           wr_cnt, rd_cnt, strobe_viol, bus_viol, ready_viol;
    bit           prev_wr, prev_rd, seen, exp_err;
    logic [W-1:0] exp_data, got_data;
    logic         got_err;

    bad = model_bad(size, addr);
    if (bad) begin
      exp_lat = 1; exp_err = 1; exp_data = 0; exp_strobe = 0;
    end else if (we) begin
      exp_lat = 3; exp_err = 0; exp_data = 0; exp_strobe = 2;
    end else if (w > TO) begin
      exp_lat = 2 + TO + 1; exp_err = 1; exp_data = 0; exp_strobe = 2;
    end else begin
      exp_lat = 3 + w; exp_err = 0; exp_data = model_ext(size, sgn, rdata); exp_strobe = 2;
    end

    check({tag, "_ready_idle"}, bus_if.req_ready, 1);
    bus_if.req_valid  = 1'b1;
    bus_if.req_we     = we;
    bus_if.req_size   = size;
    bus_if.req_signed = sgn;
    bus_if.req_addr   = addr;
    bus_if.req_wdata  = wdata;
    @(posedge clk);

    n = 0; n_resp = 0; n_strobe = 0; n_rd = 0; seen = 0;
    wr_cnt = 0; rd_cnt = 0; strobe_viol = 0; bus_viol = 0; ready_viol = 0;
    prev_wr = 0; prev_rd = 0; got_err = 0; got_data = 0;
    while (!seen && n < 30) begin
      @(negedge clk);
      n++;
      if (bus_if.req_ready) ready_viol++;
      if (bus_if.mem_wr && bus_if.mem_rd) strobe_viol++;
      if ((prev_wr && bus_if.mem_wr) || (prev_rd && bus_if.mem_rd)) strobe_viol++;
      if (bus_if.mem_wr) begin wr_cnt++; if (n_strobe == 0) n_strobe = n; end
      if (bus_if.mem_rd) begin rd_cnt++; if (n_strobe == 0) n_strobe = n; if (n_rd == 0) n_rd = n; end
      prev_wr = bus_if.mem_wr;
      prev_rd = bus_if.mem_rd;
      if (!mem_drive && !bus_free && !(we && !bad && (n == 1 || n == 2))) bus_viol++;
      if (!bad && n == 1) begin
        check({tag, "_setup_add"},  bus_if.mem_add,  addr);
        check({tag, "_setup_mode"}, bus_if.mem_mode, size);
        if (we) check({tag, "_setup_bus"}, mem_data, wdata);
      end
      if (we && !bad && n == 2) check({tag, "_strobe_bus"}, mem_data, wdata);
      if (bus_if.resp_valid) begin
        seen = 1; n_resp = n; got_err = bus_if.resp_err; got_data = bus_if.resp_data;
      end
      // Memory responder and busy-time junk requests (must be ignored).
      bus_if.mem_rd_st = 1'b0;
      mem_drive        = 1'b0;
      if (!we && n_rd != 0 && w <= TO && n == n_rd + w) begin
        bus_if.mem_rd_st = 1'b1;
        mem_rdata        = rdata;
        mem_drive        = 1'b1;
      end
      if (seen) begin
        bus_if.req_valid = 1'b0;
      end else begin
        bus_if.req_we     = 1'($urandom);
        bus_if.req_size   = 2'($urandom);
        bus_if.req_signed = 1'($urandom);
        bus_if.req_addr   = $urandom;
        bus_if.req_wdata  = $urandom;
      end
    end
    bus_if.req_valid = 1'b0;
    bus_if.mem_rd_st = 1'b0;
    mem_drive        = 1'b0;

    check({tag, "_resp_seen"},   32'(seen),        1);
    check({tag, "_latency"},     32'(n_resp),      32'(exp_lat));
    check({tag, "_err"},         got_err,          exp_err);
    check({tag, "_data"},        got_data,         exp_data);
    check({tag, "_wr_pulses"},   32'(wr_cnt),      (we && !bad) ? 1 : 0);
    check({tag, "_rd_pulses"},   32'(rd_cnt),      (!we && !bad) ? 1 : 0);
    check({tag, "_strobe_cyc"},  32'(n_strobe),    32'(exp_strobe));
    check({tag, "_strobe_rule"}, 32'(strobe_viol), 0);
    check({tag, "_bus_rule"},    32'(bus_viol),    0);
    check({tag, "_busy_ready"},  32'(ready_viol),  0);

    @(negedge clk);
    check({tag, "_pulse_once"}, bus_if.resp_valid, 0);
    check({tag, "_ready_back"}, bus_if.req_ready,  1);
    check({tag, "_data_hold"},  bus_if.resp_data,  exp_data);
  endtask

  // Accept a request, then assert reset in cycle at_n after acceptance.
  task automatic reset_mid(input string tag, input bit we, input logic [1:0] size,
                           input logic [W-1:0] addr, input logic [W-1:0] wdata, input int at_n);
    int n;
    bus_if.req_valid  = 1'b1;
    bus_if.req_we     = we;
    bus_if.req_size   = size;
    bus_if.req_signed = 1'b0;
    bus_if.req_addr   = addr;
    bus_if.req_wdata  = wdata;
    @(posedge clk);
    @(negedge clk);
    bus_if.req_valid = 1'b0;
    n = 1;
    while (n < at_n) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_pre_busy"}, bus_if.req_ready, 0);
    if (we) check({tag, "_pre_bus"}, mem_data, wdata);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs({tag, "_now"});
    @(negedge clk);
    check_reset_outputs({tag, "_held"});
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    rst_n             = 1'b1;
    mem_drive         = 1'b0;
    mem_rdata         = '0;
    bus_if.req_valid  = 1'b0;
    bus_if.req_we     = 1'b0;
    bus_if.req_size   = 2'd0;
    bus_if.req_signed = 1'b0;
    bus_if.req_addr   = '0;
    bus_if.req_wdata  = '0;
    bus_if.mem_rd_st  = 1'b0;
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("rst");
    repeat (3) @(negedge clk);
    check_reset_outputs("rst_hold");
    rst_n = 1'b1;
    @(negedge clk);

    run_req("st_word",   1, 2'd0, 0, 32'h4, 32'hDEADBEEF, 32'h0, 1);
    run_req("ld_sbyte",  0, 2'd2, 1, 32'h5, 32'h0, 32'h000000F0, 1);
    run_req("ld_ubyte",  0, 2'd2, 0, 32'h5, 32'h0, 32'h000000F0, 2);
    run_req("ld_shalf1", 0, 2'd1, 1, 32'h2, 32'h0, 32'h00007FFF, 1);
    run_req("ld_shalf2", 0, 2'd1, 1, 32'h2, 32'h0, 32'h00008001, 3);
    run_req("ld_misal",  0, 2'd0, 0, 32'h6, 32'h0, 32'h12345678, 1);
    run_req("ld_size3",  0, 2'd3, 0, 32'h0, 32'h0, 32'h12345678, 1);
    run_req("st_misal",  1, 2'd1, 0, 32'h3, 32'hCAFEF00D, 32'h0, 1);
    run_req("ld_tmo",    0, 2'd0, 0, 32'h40, 32'h0, 32'h0, TO + 1);
    run_req("ld_last",   0, 2'd0, 0, 32'h44, 32'h0, 32'hA5A55A5A, TO);

    run_req("ld_prime",  0, 2'd0, 0, 32'h108, 32'h0, 32'h55AA1234, 2);
    reset_mid("rst_wait",  0, 2'd1, 32'h10A, 32'h0, 4);
    run_req("after_rst1", 0, 2'd2, 1, 32'h33, 32'h0, 32'h00000081, 1);
    reset_mid("rst_setup", 1, 2'd0, 32'h20, 32'h13579BDF, 1);
    run_req("after_rst2", 1, 2'd0, 0, 32'h24, 32'h2468ACE0, 32'h0, 1);

    for (int i = 0; i < 200; i++) begin
      logic [1:0]   size;
      logic [W-1:0] addr;
      bit           we, sgn;
      we   = 1'($urandom);
      sgn  = 1'($urandom);
      size = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
      run_req("rnd", we, size, sgn, addr, $urandom, $urandom, $urandom_range(1, TO + 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage sequencer between the EX/MEM pipeline register and the data memory.
- Accepts one load/store request at a time and produces the data memory's address, mode, write/read strobes and store data.
- Captures the returned word after the read handshake, sign-extends loads and reports completion or error to the pipeline.
- Holds off the pipeline (req_ready low) while an access is in flight.

Parameters:
- WIDTH, 32 (`WIDTH), data/address width.
- TIMEOUT, 8, maximum WAIT cycles for mem_rd_st before a load is aborted with error.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  unit idle, request accepted when valid&ready
- req_we  input  1  1=store, 0=load
- req_size  input  2  0=word, 1=halfword, 2=byte, 3=illegal
- req_signed  input  1  sign-extend load result
- req_addr  input  WIDTH  byte address
- req_wdata  input  WIDTH  store data (right-justified)
- resp_valid  output  1  one-cycle completion pulse
- resp_data  output  WIDTH  load result (0 for stores/errors)
- resp_err  output  1  misaligned, illegal size or timeout
- mem_add  output  WIDTH  memory address
- mem_data  inout  WIDTH  shared data bus
- mem_wr  output  1  write strobe (rising edge commits)
- mem_rd  output  1  read strobe (rising edge launches read)
- mem_rd_st  input  1  read data valid from memory
- mem_mode  output  2  equals latched req_size

Behaviour:
- Reset (async, rst_n=0): state IDLE, req_ready=1, resp_valid=0, resp_data=0, resp_err=0, mem_add=0, mem_mode=0, mem_wr=0, mem_rd=0, mem_data released (Z), timeout counter=0.
- FSM states: IDLE, SETUP, STROBE, WAIT, DONE, ERR.
- IDLE:
  - req_ready=1.
  - On req_valid, latch we/size/signed/addr/wdata.
  - If size==3, or size==0 with addr[1:0]!=0, or size==1 with addr[0]!=0, go to ERR.
  - Otherwise go to SETUP.
- SETUP (1 cycle):
  - mem_add and mem_mode driven from the latches; strobes low.
  - For stores, mem_data is driven with the latched wdata.
  - Address, mode and data are therefore stable one full cycle before any strobe edge.
- STROBE (1 cycle):
  - Store: mem_wr=1, data still driven; go to DONE.
  - Load: mem_rd=1, bus released; go to WAIT.
- WAIT (load only):
  - mem_rd=0; bus released.
  - If mem_rd_st===1, capture mem_data into resp_data:
    - byte: bits[7:0], extended with bit 7 if signed, else zero.
    - halfword: bits[15:0], extended with bit 15 if signed, else zero.
    - word: unchanged.
  - Then go to DONE.
  - Otherwise increment the counter. When it reaches TIMEOUT, go to ERR.
- DONE:
  - resp_valid=1, resp_err=0 for exactly one cycle; strobes low; bus released.
  - Return to IDLE; resp_data holds until the next request is accepted.
- ERR:
  - resp_valid=1, resp_err=1, resp_data=0 for one cycle; no strobe was or is issued.
  - Return to IDLE.
- Latency:
  - Store: 3 cycles accept→resp_valid.
  - Load: 4 cycles minimum.
  - Error: 1 cycle.
- Bus rule: mem_data is driven only in SETUP/STROBE of a store and is Z in every other state, including reset.
- req_ready=0 in every non-IDLE state; requests presented then are ignored, not queued.
- The counter clears on every entry to SETUP.
- Reset mid-operation aborts immediately:
  - Strobes drop and the bus releases asynchronously.
  - An interrupted store with mem_wr already high is considered committed.
- mem_wr and mem_rd are never high in the same cycle and never high for more than one cycle.

Decomposition:
- Shared params package: WIDTH, size encodings (SZ_WORD=0, SZ_HALF=1, SZ_BYTE=2), FSM state encodings, TIMEOUT default.
- One natural sub-module: load_extend (combinational size/sign extension of the captured word).

Test Plan:
- Word store addr=0x4 wdata=0xDEADBEEF:
  - mem_wr pulses once, with mem_add=0x4, mode=0 and bus=0xDEADBEEF stable the prior cycle.
  - resp_valid on cycle 3, resp_err=0.
- Signed byte load addr=0x5, memory returns 0x000000F0 → resp_data=0xFFFFFFF0. Same request unsigned → 0x000000F0.
- Signed halfword load addr=0x2, memory returns 0x00007FFF → resp_data=0x00007FFF. Returns 0x00008001 → 0xFFFF8001.
- Misaligned word load addr=0x6, and size=3 at addr=0x0:
  - No mem_rd/mem_wr edge.
  - resp_valid with resp_err=1 one cycle after accept, resp_data=0.
- Load with mem_rd_st held 0 → resp_err=1 after exactly TIMEOUT=8 WAIT cycles; req_ready returns to 1 next cycle.
- rst_n asserted during WAIT of a load and during SETUP of a store:
  - All outputs return to reset values at once; bus is Z.
  - The next request completes normally.
